// File: rtl/bf16_to_bcd_if.sv
// rtl/bf16_to_bcd_if.sv - request/result bundle between the arctan stage, the BF16-to-BCD converter and the display path
interface bf16_to_bcd_if #(
    parameter int FRAC_DIGITS = 2
);
    localparam int NDIG = 3 + FRAC_DIGITS;

    logic                start;
    logic [15:0]         bf16_in;
    logic [4*NDIG-1:0]   bcd;
    logic                neg;
    logic                overflow;
    logic                is_nan;
    logic                busy;
    logic                done;

    modport master (
        output start, bf16_in,
        input  bcd, neg, overflow, is_nan, busy, done
    );

    modport slave (
        input  start, bf16_in,
        output bcd, neg, overflow, is_nan, busy, done
    );
endinterface

// File: rtl/bf16_to_bcd.sv
// rtl/bf16_to_bcd.sv - multi-cycle BF16 to sign-magnitude BCD converter (3 integer + FRAC_DIGITS fraction digits)
module bf16_to_bcd #(
    parameter int FRAC_DIGITS = 2
) (
    input  logic         clk,
    input  logic         rst,
    bf16_to_bcd_if.slave bus
);
    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    localparam int NDIG   = 3 + FRAC_DIGITS;
    localparam int SCALE  = pow10(FRAC_DIGITS);
    localparam int LIMIT  = pow10(NDIG);
    localparam int BIN_W  = $clog2(LIMIT);
    localparam int FX_W   = 26;
    localparam int PROD_W = FX_W + 10;
    localparam int Q_W    = PROD_W - 16;
    localparam int CNT_W  = $clog2(BIN_W);
    localparam int DIG_W  = 4 * NDIG;

    localparam logic [PROD_W-1:0] SCALE_C = PROD_W'(SCALE);
    localparam logic [PROD_W-1:0] ROUND_C = PROD_W'(32768);
    localparam logic [Q_W-1:0]    LIMIT_Q = Q_W'(LIMIT);
    localparam logic [CNT_W-1:0]  LAST_C  = CNT_W'(BIN_W - 1);

    typedef enum logic [2:0] {
        IDLE, UNPACK, ALIGN, SCALE_ST, CHECK, BCD, OUTPUT
    } state_t;

    state_t state_q, state_d;

    logic [15:0]       x_q, x_d;
    logic              s_q, s_d;
    logic [7:0]        e_q, e_d;
    logic [7:0]        m_q, m_d;
    logic              nan_q, nan_d;
    logic              big_q, big_d;
    logic [FX_W-1:0]   fx_q, fx_d;
    logic [Q_W-1:0]    q_q, q_d;
    logic              res_neg_q, res_neg_d;
    logic              res_ovf_q, res_ovf_d;
    logic              res_nan_q, res_nan_d;
    logic [BIN_W-1:0]  bin_q, bin_d;
    logic [DIG_W-1:0]  work_q, work_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIG_W-1:0]  bcd_q, bcd_d;
    logic              neg_q, neg_d;
    logic              ovf_q, ovf_d;
    logic              is_nan_q, is_nan_d;
    logic              done_q, done_d;
    logic              busy_c;
    logic              special_c;

    function automatic logic [DIG_W-1:0] add3(input logic [DIG_W-1:0] w);
        logic [DIG_W-1:0] r;
        r = w;
        for (int k = 0; k < NDIG; k++)
            if (w[4*k +: 4] >= 4'd5) r[4*k +: 4] = w[4*k +: 4] + 4'd3;
        return r;
    endfunction

    // Anything that skips double-dabble: NaN, Inf/huge exponent, out of range, or rounds to zero
    assign special_c = nan_q || big_q || (q_q >= LIMIT_Q) || (q_q == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.start) state_d = UNPACK;
            UNPACK:   state_d = ALIGN;
            ALIGN:    state_d = SCALE_ST;
            SCALE_ST: state_d = CHECK;
            CHECK:    state_d = special_c ? OUTPUT : BCD;
            BCD:      if (cnt_q == LAST_C) state_d = OUTPUT;
            OUTPUT:   state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_c = (state_q != IDLE);
        done_d = (state_q == OUTPUT);
    end

    always_comb begin
        x_d       = x_q;
        s_d       = s_q;
        e_d       = e_q;
        m_d       = m_q;
        nan_d     = nan_q;
        big_d     = big_q;
        fx_d      = fx_q;
        q_d       = q_q;
        res_neg_d = res_neg_q;
        res_ovf_d = res_ovf_q;
        res_nan_d = res_nan_q;
        bin_d     = bin_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        is_nan_d  = is_nan_q;
        case (state_q)
            IDLE: if (bus.start) x_d = bus.bf16_in;
            UNPACK: begin
                s_d   = x_q[15];
                e_d   = x_q[14:7];
                m_d   = {1'b1, x_q[6:0]};
                nan_d = (x_q[14:7] == 8'hFF) && (x_q[6:0] != 7'd0);
            end
            ALIGN: begin
                // Q10.16: a shift of 118 on the exponent puts the mantissa LSB at the binary point's 2^-16
                big_d = (e_q >= 8'd137);
                if (e_q == 8'd0 || e_q >= 8'd137) fx_d = '0;
                else if (e_q >= 8'd118)           fx_d = FX_W'(m_q) << (e_q - 8'd118);
                else                              fx_d = FX_W'(m_q) >> (8'd118 - e_q);
            end
            SCALE_ST: q_d = Q_W'((PROD_W'(fx_q) * SCALE_C + ROUND_C) >> 16);
            CHECK: begin
                work_d    = '0;
                bin_d     = q_q[BIN_W-1:0];
                cnt_d     = '0;
                res_nan_d = nan_q;
                res_ovf_d = !nan_q && (big_q || (q_q >= LIMIT_Q));
                res_neg_d = !nan_q && s_q && (big_q || (q_q != '0));
            end
            BCD: begin
                {work_d, bin_d} = {add3(work_q), bin_q} << 1;
                cnt_d           = cnt_q + 1'b1;
            end
            OUTPUT: begin
                bcd_d    = work_q;
                neg_d    = res_neg_q;
                ovf_d    = res_ovf_q;
                is_nan_d = res_nan_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q       <= '0;
            s_q       <= 1'b0;
            e_q       <= '0;
            m_q       <= '0;
            nan_q     <= 1'b0;
            big_q     <= 1'b0;
            fx_q      <= '0;
            q_q       <= '0;
            res_neg_q <= 1'b0;
            res_ovf_q <= 1'b0;
            res_nan_q <= 1'b0;
            bin_q     <= '0;
            work_q    <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
            ovf_q     <= 1'b0;
            is_nan_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            x_q       <= x_d;
            s_q       <= s_d;
            e_q       <= e_d;
            m_q       <= m_d;
            nan_q     <= nan_d;
            big_q     <= big_d;
            fx_q      <= fx_d;
            q_q       <= q_d;
            res_neg_q <= res_neg_d;
            res_ovf_q <= res_ovf_d;
            res_nan_q <= res_nan_d;
            bin_q     <= bin_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
            ovf_q     <= ovf_d;
            is_nan_q  <= is_nan_d;
            done_q    <= done_d;
        end
    end

    assign bus.bcd      = bcd_q;
    assign bus.neg      = neg_q;
    assign bus.overflow = ovf_q;
    assign bus.is_nan   = is_nan_q;
    assign bus.busy     = busy_c;
    assign bus.done     = done_q;
endmodule
